// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: width codes, FSM states and
// byte-enable helpers used by the LSU and its load aligner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_t;

  // Low two funct3 bits give the access size for both loads and stores.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   byte_en = BE_B << off;
      2'b01:   byte_en = BE_H << off;
      default: byte_en = BE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Valid/grant data-memory bus between the LSU (master) and memory (slave).
interface lsu_mem_stage_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  input  bus_gnt, bus_rvalid, bus_rdata);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
                  output bus_gnt, bus_rvalid, bus_rdata);
endinterface

// File: rtl/lsu_mem_stage_load_align.sv
// Combinational load aligner: lane shift followed by sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  assign sh = word_i >> {off_i, 3'b000};

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{sh[7]}}, sh[7:0]};
      F3_H:    data_o = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   data_o = {24'd0, sh[7:0]};
      F3_HU:   data_o = {16'd0, sh[15:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage load/store unit: decodes the M-stage access, runs one bus
// transaction at a time with a timeout, and stalls the pipeline until it completes.
module lsu_mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMemM,
  output logic        FaultM,
  output logic        BusErrM,
  lsu_mem_stage_if.master bus
);

  lsu_state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic        access, legal_code, misalign, fault, go, timeout;
  logic [31:0] ext_data;

  assign access   = MemReadM | MemWriteM;
  assign misalign = ((Funct3M[1:0] == 2'b01) &  ALUResultM[0]) |
                    ((Funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
  assign fault    = access & (~legal_code | misalign);
  assign go       = access & ~fault;
  assign timeout  = (cnt_q == TO_W'(TIMEOUT_CYC));

  always_comb begin
    legal_code = 1'b0;
    if (MemReadM && MemWriteM)
      legal_code = 1'b0;
    else if (MemReadM)
      legal_code = Funct3M inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    else
      legal_code = Funct3M inside {F3_B, F3_H, F3_W};
  end

  load_align u_align (
    .word_i   (bus.bus_rdata),
    .off_i    (ALUResultM[1:0]),
    .funct3_i (Funct3M),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    StallMemM     = 1'b0;
    FaultM        = 1'b0;
    BusErrM       = 1'b0;
    ReadDataM     = 32'd0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = 32'd0;
    bus.bus_be    = 4'd0;
    bus.bus_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        // Gated by reset so nothing combinational escapes while reset is held.
        FaultM    = fault & reset;
        StallMemM = go & reset;
        if (go) begin
          state_d = REQ;
          cnt_d   = '0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        StallMemM     = 1'b1;
        bus.bus_req   = ~timeout;
        bus.bus_we    = MemWriteM;
        bus.bus_addr  = {ALUResultM[31:2], 2'b00};
        bus.bus_be    = byte_en(Funct3M, ALUResultM[1:0]);
        bus.bus_wdata = WriteDataM << {ALUResultM[1:0], 3'b000};
        cnt_d         = cnt_q + 1'b1;
        if (bus.bus_gnt) begin
          if (MemWriteM) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_R;
            cnt_d   = '0;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end
      end
      WAIT_R: begin
        StallMemM = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (bus.bus_rvalid) begin
          rdata_d = ext_data;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        ReadDataM = rdata_q;
        BusErrM   = err_q;
        err_d     = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized
// transactions checked every cycle against a transaction-level timing model.
module tb_lsu_mem_stage;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMemM, FaultM, BusErrM;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMemM  (StallMemM),
    .FaultM     (FaultM),
    .BusErrM    (BusErrM),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle expectations, written by the stimulus process, read by the compare process.
  bit          chk_en = 1'b0;
  logic        e_stall, e_fault, e_err, e_req, e_we;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",  {31'd0, StallMemM}, {31'd0, e_stall});
      chk("fault",  {31'd0, FaultM},    {31'd0, e_fault});
      chk("buserr", {31'd0, BusErrM},   {31'd0, e_err});
      chk("rdata",  ReadDataM,          e_rdata);
      chk("req",    {31'd0, bus.bus_req}, {31'd0, e_req});
      if (e_req) begin
        chk("we",    {31'd0, bus.bus_we}, {31'd0, e_we});
        chk("addr",  bus.bus_addr,  e_addr);
        chk("be",    {28'd0, bus.bus_be}, {28'd0, e_be});
        chk("wdata", bus.bus_wdata, e_wdata);
      end
    end
  end

  // ---------------- reference model (spec rules, plain arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_fault(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr);
    int off;
    if (!rd && !wr) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if (wr && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 1'b1;
    off = int'(addr % 4);
    return (off % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] w, input int off,
                                            input logic [2:0] f3);
    int unsigned v, b, h;
    v = w >> (8 * off);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return v;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input int off);
    int unsigned m;
    m = ((1 << m_size(f3)) - 1) << off;
    return m[3:0];
  endfunction

  // One M-stage access from its first IDLE cycle through DONE (or the fault cycle).
  // g: REQ cycle index of gnt (>=TO means never); r: WAIT_R cycle index of rvalid.
  task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int g, input int r,
                         output int stalls, output int reqs, output int faults,
                         output int errs, output logic [31:0] dval,
                         output logic [31:0] a1, output logic [31:0] wd1,
                         output logic [3:0] be1);
    bit          flt, tg, tr, got;
    int          ws, done_c, req_last, off;
    logic [31:0] exp_data;
    flt = m_fault(rd, wr, f3, addr);
    tg  = (g >= TO);
    ws  = 2 + g;
    tr  = rd && !tg && (r >= TO);
    off = int'(addr % 4);
    if (flt)     done_c = 0;
    else if (tg) done_c = TO + 2;
    else if (wr) done_c = 2 + g;
    else if (tr) done_c = ws + TO + 1;
    else         done_c = ws + r + 1;
    req_last = tg ? TO : 1 + g;
    exp_data = (flt || tg || tr || wr) ? 32'd0 : m_extract(rdata, off, f3);
    stalls = 0; reqs = 0; faults = 0; errs = 0; dval = 32'd0;
    a1 = 32'd0; wd1 = 32'd0; be1 = 4'd0; got = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        MemReadM = rd; MemWriteM = wr; Funct3M = f3;
        ALUResultM = addr; WriteDataM = wdata;
      end
      bus.bus_gnt = !flt && !tg && (c == 1 + g);
      bus.bus_rdata = rdata;
      if (rd && !flt && !tg && c >= ws && c < done_c) begin
        bus.bus_rvalid = !tr && (c == ws + r);
      end else begin
        bus.bus_rvalid = ($urandom_range(0, 3) == 0);
        if (bus.bus_rvalid) bus.bus_rdata = $urandom;
      end
      e_stall = !flt && (c < done_c);
      e_fault = flt;
      e_err   = !flt && (c == done_c) && (tg || tr);
      e_rdata = (c == done_c) ? exp_data : 32'd0;
      e_req   = !flt && (c >= 1) && (c <= req_last);
      e_we    = wr;
      e_addr  = addr & 32'hFFFF_FFFC;
      e_be    = m_be(f3, off);
      e_wdata = wdata << (8 * off);
      #3;
      stalls += int'(StallMemM);
      reqs   += int'(bus.bus_req);
      faults += int'(FaultM);
      if (c == done_c) begin
        dval = ReadDataM;
        errs = int'(BusErrM);
      end
      if (bus.bus_req && !got) begin
        got = 1'b1; a1 = bus.bus_addr; wd1 = bus.bus_wdata; be1 = bus.bus_be;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      MemReadM = 1'b0; MemWriteM = 1'b0;
      Funct3M = 3'($urandom_range(0, 7)); ALUResultM = $urandom;
      bus.bus_gnt = 1'b0;
      bus.bus_rvalid = ($urandom_range(0, 1) == 0);
      bus.bus_rdata = $urandom;
      e_stall = 1'b0; e_fault = 1'b0; e_err = 1'b0; e_rdata = 32'd0; e_req = 1'b0;
    end
  endtask

  int          st, rq, ft, er;
  logic [31:0] dv, a1, wd1;
  logic [3:0]  be1;

  initial begin
    // Reset with a legal load and active bus inputs presented.
    reset = 1'b0;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2;
    ALUResultM = 32'h0000_0100; WriteDataM = 32'h5555_AAAA;
    bus.bus_gnt = 1'b1; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
    e_stall = 0; e_fault = 0; e_err = 0; e_req = 0; e_we = 0;
    e_rdata = 0; e_addr = 0; e_wdata = 0; e_be = 0;
    #3;
    chk("rst_stall",  {31'd0, StallMemM}, 32'd0);
    chk("rst_req",    {31'd0, bus.bus_req}, 32'd0);
    chk("rst_rdata",  ReadDataM, 32'd0);
    chk("rst_fault",  {31'd0, FaultM}, 32'd0);
    chk("rst_buserr", {31'd0, BusErrM}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    MemReadM = 1'b0; bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
    reset = 1'b1;
    chk_en = 1'b1;
    idle_cycles(2);

    // Model pinned to hand-computed values.
    chk("model_lb",  m_extract(32'h80FF_1234, 3, 3'd0), 32'hFFFF_FF80);
    chk("model_lbu", m_extract(32'h80FF_1234, 3, 3'd4), 32'h0000_0080);
    chk("model_be_sh", {28'd0, m_be(3'd1, 2)}, 32'h0000_000C);

    run_txn(1, 0, 3'd0, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0, st, rq, ft, er, dv, a1, wd1, be1);
    chk("lb_data", dv, 32'hFFFF_FF80);
    chk("lb_stall_cycles", st, 3);
    run_txn(1, 0, 3'd4, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0, 0, st, rq, ft, er, dv, a1, wd1, be1);
    chk("lbu_data", dv, 32'h0000_0080);

    run_txn(0, 1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'd0, 0, 0, st, rq, ft, er, dv, a1, wd1, be1);
    chk("sh_addr", a1, 32'h0000_2000);
    chk("sh_be", {28'd0, be1}, 32'h0000_000C);
    chk("sh_wdata", wd1, 32'hBEEF_0000);
    chk("sh_stall_cycles", st, 2);
    chk("sh_rdata", dv, 32'd0);

    run_txn(1, 0, 3'd2, 32'h0000_3001, 32'd0, 32'h1111_1111, 0, 0, st, rq, ft, er, dv, a1, wd1, be1);
    chk("misal_fault", ft, 1);
    chk("misal_stall", st, 0);
    chk("misal_req", rq, 0);
    idle_cycles(1);

    run_txn(1, 0, 3'd2, 32'h0000_4000, 32'd0, 32'h1234_5678, 5, 2, st, rq, ft, er, dv, a1, wd1, be1);
    chk("lw_wait_req_cycles", rq, 6);
    chk("lw_wait_stall", st, 10);
    chk("lw_wait_data", dv, 32'h1234_5678);

    run_txn(1, 0, 3'd2, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 99, 0, st, rq, ft, er, dv, a1, wd1, be1);
    chk("to_req_cycles", rq, TO);
    chk("to_buserr", er, 1);
    chk("to_data", dv, 32'd0);
    idle_cycles(2);

    // Reset while waiting for read data.
    chk_en = 1'b0;
    @(posedge clk); #1;
    MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd2; ALUResultM = 32'h0000_6000;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
    @(posedge clk); #1; bus.bus_gnt = 1'b1;
    @(posedge clk); #1; bus.bus_gnt = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_stall", {31'd0, StallMemM}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'd0, bus.bus_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, StallMemM}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; MemReadM = 1'b0;
    bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hAAAA_5555;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("post_rst_stall", {31'd0, StallMemM}, 32'd0);
      chk("post_rst_rdata", ReadDataM, 32'd0);
      chk("post_rst_buserr", {31'd0, BusErrM}, 32'd0);
      @(posedge clk); #1;
    end
    bus.bus_rvalid = 1'b0;
    chk_en = 1'b1;

    // Randomized accesses.
    for (int n = 0; n < 300; n++) begin
      bit rd, wr;
      int sel, g, r;
      sel = $urandom_range(0, 9);
      rd = (sel < 5) || (sel == 9);
      wr = (sel >= 5);
      g = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, TO - 1);
      r = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, TO - 1);
      run_txn(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, g, r,
              st, rq, ft, er, dv, a1, wd1, be1);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the memory-access stage of the 5-stage pipelined core.
- Consumes ALUResultM/WriteDataM from the datapath and drives a valid/grant data-memory bus.
- Returns aligned, sign/zero-extended ReadDataM into the Mem->WB pipeline register.
- Raises a stall request to the hazard unit while a bus transaction is outstanding, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYC, 255: max cycles waiting for bus_gnt or bus_rvalid before abort.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  load in M stage.
- MemWriteM  in  1  store in M stage.
- Funct3M  in  3  RV32I load/store width/sign code.
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store data, right-justified.
- ReadDataM  out  32  extended load result to IMem_IW.
- StallMemM  out  1  stall request to hazard unit; freezes IF..M.
- FaultM  out  1  one-cycle flag: misaligned or illegal access.
- BusErrM  out  1  one-cycle flag: bus timeout.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, {ALUResultM[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid this cycle.
- bus_rdata  in  32  read word.

Behaviour:
- Reset (reset=0, async): state=IDLE, counter=0, rdata_q=0, err_q=0. All outputs 0 while reset is held.
- Decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code, or MemReadM and MemWriteM both set, is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
- Store data: bus_wdata = WriteDataM<<(8*addr[1:0]); stores replicate nothing.
- FSM states: IDLE, REQ, WAIT_R, DONE.
  - IDLE, access legal and aligned: go to REQ. StallMemM=1 combinationally this cycle.
  - IDLE, access faulting: FaultM=1 and ReadDataM=0 this cycle. No bus activity, no stall; stay IDLE.
  - IDLE, no access: stay IDLE, StallMemM=0.
  - REQ: bus_req=1, bus_we, bus_addr, bus_be, bus_wdata held stable from M-stage inputs (stable because the pipeline is stalled). On bus_gnt, a store goes to DONE and a load goes to WAIT_R.
  - WAIT_R: bus_req=0. On bus_rvalid, rdata_q <= extract(bus_rdata, addr[1:0], Funct3M), then go to DONE.
    - Extract: shift right by 8*addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes through.
  - DONE: StallMemM=0, ReadDataM=rdata_q (0 for stores), BusErrM=err_q. Next state IDLE, err_q cleared.
- StallMemM = (IDLE & legal aligned access) | REQ | WAIT_R.
- DONE lasts exactly one cycle, so each access is seen once. The M-stage instruction advances at the end of DONE.
- Latency: a zero-wait bus (gnt in the first REQ cycle, rvalid the next cycle) gives loads 4 cycles (IDLE, REQ, WAIT_R, DONE) and stores 3 cycles.
- Timeout:
  - Counter clears on entry to REQ and on entry to WAIT_R, and increments each cycle in REQ/WAIT_R.
  - When counter reaches TIMEOUT_CYC without gnt/rvalid: set err_q=1, rdata_q=0, go to DONE.
  - In REQ, bus_req drops on the abort cycle.
- Simultaneous events:
  - bus_gnt and timeout in the same cycle: gnt wins.
  - bus_rvalid and timeout in the same cycle: rvalid wins.
  - bus_rvalid outside WAIT_R is ignored.
- Reset mid-transaction: immediate return to IDLE and bus_req=0. The bus is responsible for discarding the in-flight response.

Decomposition:
- Shared package mem_pkg holds:
  - Funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum lsu_state_t {IDLE, REQ, WAIT_R, DONE}.
  - Byte-enable base constants.
- One combinational sub-module, load_align, contains the shift plus sign/zero-extend. It is reused by any future cache path.

Test Plan:
- LB at 0x1003, bus_rdata=0x80FF_1234, zero-wait bus -> StallMemM high 3 cycles, then ReadDataM=0xFFFF_FF80 in DONE; LBU same -> 0x0000_0080.
- SH at 0x2002, WriteDataM=0xDEAD_BEEF -> bus_addr=0x2000, bus_be=4'b1100, bus_wdata=0xBEEF_0000, bus_we=1; DONE after gnt.
- LW at 0x3001 -> FaultM=1 for one cycle, StallMemM=0, bus_req never asserted, ReadDataM=0.
- LW at 0x4000, bus_gnt delayed 5 cycles, rvalid 3 cycles later with 0x1234_5678 -> bus_req held with stable addr for 6 cycles; ReadDataM=0x1234_5678; total stall 10 cycles.
- LW, TIMEOUT_CYC=4, bus never grants -> bus_req drops after 4 REQ cycles, BusErrM=1 and ReadDataM=0 in DONE, then IDLE.
- Assert reset low while in WAIT_R -> state IDLE, bus_req=0 and StallMemM=0 immediately; a later rvalid is ignored.
